lib_arb_wrr_lock: RTL and testbench



---
 rtl/lib_arb_pkg.sv | 32 +++
 rtl/lib_ppe_onehot.sv | 20 ++
 rtl/lib_arb_wrr_lock.sv | 150 +++++++++++++++
 tb/tb_lib_arb_wrr_lock.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lib_arb_pkg.sv
// Shared types and helpers for the LIB arbiters; vectors are bit k = requester k, up to ARB_MAX_N requesters.
package lib_arb_pkg;

  localparam int unsigned ARB_MAX_N = 32;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  function automatic logic [ARB_MAX_N-1:0] onehot_to_idx(input logic [ARB_MAX_N-1:0] v);
    logic [ARB_MAX_N-1:0] idx;
    idx = '0;
    for (int unsigned k = 0; k < ARB_MAX_N; k++) begin
      if (v[k]) idx = k;
    end
    return idx;
  endfunction

  // Rotate a one-hot vector up by one within the low n bits, wrapping bit n-1 to bit 0.
  function automatic logic [ARB_MAX_N-1:0] rotate_onehot(input logic [ARB_MAX_N-1:0] v,
                                                         input int unsigned n);
    logic [ARB_MAX_N-1:0] mask;
    mask = (32'd1 << n) - 32'd1;
    return ((v << 1) & mask) | ((v >> (n - 1)) & 32'd1);
  endfunction

  function automatic logic [ARB_MAX_N-1:0] clamp_weight(input logic [ARB_MAX_N-1:0] w);
    return (w == '0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/lib_ppe_onehot.sv
// Combinational programmable priority encoder: first request at or after the one-hot priority, wrapping.
module lib_ppe_onehot #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] prio,
  output logic [N-1:0] gnt
);

  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] dbl_gnt;

  // Subtracting the priority clears the lowest request at or above it; the doubled copy supplies the wrap carry.
  always_comb begin
    dbl_req = {req, req};
    dbl_gnt = dbl_req & ~(dbl_req - {{N{1'b0}}, prio});
    gnt     = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];
  end

endmodule

// File: rtl/lib_arb_wrr_lock.sv
// Weighted round-robin arbiter with packet lock; grant registered 1 cycle after request, held through i_ready=0 stalls.
// LIB_ARB_WRR_EN enables per-requester credit weights; otherwise plain round robin with packet lock.
module lib_arb_wrr_lock
  import lib_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int WEIGHT_W = 4,
  parameter int IDX_W    = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:N-1]          i_request,
  input  logic [0:N-1]          i_last,
  input  logic [N*WEIGHT_W-1:0] i_weight,
  input  logic                  i_ready,
  output logic [0:N-1]          o_grant,
  output logic [IDX_W-1:0]      o_grant_idx,
  output logic                  o_valid,
  output logic                  o_locked
);

  arb_state_e   state;
  arb_state_e   state_nxt;
  logic [N-1:0] req_v;
  logic [N-1:0] last_v;
  logic [N-1:0] win;
  logic [N-1:0] ptr;
  logic [N-1:0] ptr_end;
  logic [N-1:0] ptr_skip;
  logic [N-1:0] grant_q;
  logic         locked_q;
  logic         valid;
  logic         xfer;
  logic         req_win;
  logic         last_win;
  logic         drop;
  logic         end_pkt;

  always_comb begin
    req_v  = '0;
    last_v = '0;
    for (int k = 0; k < N; k++) begin
      req_v[k]  = i_request[k];
      last_v[k] = i_last[k];
    end
  end

  lib_ppe_onehot #(.N(N)) u_ppe (
    .req  (req_v),
    .prio (ptr),
    .gnt  (win)
  );

  assign valid    = |grant_q;
  assign xfer     = valid & i_ready;
  assign req_win  = |(req_v & grant_q);
  assign last_win = |(last_v & grant_q);
  // A dropped request wins over a same-cycle transfer: the beat is not counted.
  assign drop     = (state == ARB_BUSY) && !req_win;
  assign end_pkt  = (state == ARB_BUSY) && !drop && xfer && last_win;
  assign ptr_skip = N'(rotate_onehot(32'(grant_q), N));

`ifdef LIB_ARB_WRR_EN
  logic [WEIGHT_W-1:0] credit;
  logic [WEIGHT_W-1:0] credit_dec;
  logic [WEIGHT_W-1:0] weight_sel;
  logic [N-1:0]        owner;
  logic                owner_vld;

  always_comb begin
    weight_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (win[k]) weight_sel = i_weight[k*WEIGHT_W +: WEIGHT_W];
    end
  end

  assign credit_dec = (credit != '0) ? credit - WEIGHT_W'(1) : '0;
  // Keep priority on the winner while it still has credit left for another packet.
  assign ptr_end    = (credit_dec == '0) ? ptr_skip : grant_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit    <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
    end else if (state == ARB_IDLE) begin
      if ((|req_v) && (!owner_vld || (owner != win))) begin
        credit    <= WEIGHT_W'(clamp_weight(32'(weight_sel)));
        owner     <= win;
        owner_vld <= 1'b1;
      end
    end else if (drop) begin
      credit    <= '0;
      owner_vld <= 1'b0;
    end else if (end_pkt) begin
      credit <= credit_dec;
      if (credit_dec == '0) owner_vld <= 1'b0;
    end
  end
`else
  logic unused_weight;
  assign unused_weight = ^i_weight;
  assign ptr_end       = ptr_skip;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (|req_v) state_nxt = ARB_BUSY;
      ARB_BUSY: if (drop || end_pkt) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q  <= '0;
      ptr      <= {{(N-1){1'b0}}, 1'b1};
      locked_q <= 1'b0;
    end else if (state == ARB_IDLE) begin
      if (|req_v) grant_q <= win;
    end else if (drop) begin
      grant_q  <= '0;
      locked_q <= 1'b0;
      ptr      <= ptr_skip;
    end else if (xfer) begin
      if (last_win) begin
        grant_q  <= '0;
        locked_q <= 1'b0;
        ptr      <= ptr_end;
      end else begin
        locked_q <= 1'b1;
      end
    end
  end

  always_comb begin
    o_grant = '0;
    for (int k = 0; k < N; k++) o_grant[k] = grant_q[k];
    o_valid     = valid;
    o_locked    = locked_q;
    o_grant_idx = valid ? IDX_W'(onehot_to_idx(32'(grant_q))) : '0;
  end

endmodule

// File: tb/tb_lib_arb_wrr_lock.sv
// Directed bench for lib_arb_wrr_lock (N=4, WEIGHT_W=4); expected sequences follow the LIB_ARB_WRR_EN build setting.
module tb_lib_arb_wrr_lock;

  localparam int N = 4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [0:N-1] req;
  logic [0:N-1] last;
  logic [N*W-1:0] weight;
  logic         ready;
  logic [0:N-1] grant;
  logic [1:0]   gidx;
  logic         valid;
  logic         locked;

  int n_chk = 0;
  int n_err = 0;
  int seq[16];
  int seq_cyc[16];
  int nseq;

  lib_arb_wrr_lock #(.N(N), .WEIGHT_W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_request   (req),
    .i_last      (last),
    .i_weight    (weight),
    .i_ready     (ready),
    .o_grant     (grant),
    .o_grant_idx (gidx),
    .o_valid     (valid),
    .o_locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    last  = '0;
    ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Record the index of each granted packet; every grant must be one-hot.
  task automatic collect(input int cnt);
    int cyc;
    cyc  = 0;
    nseq = 0;
    while (nseq < cnt && cyc < 40 * cnt) begin
      step();
      cyc++;
      if (valid) begin
        check($sformatf("onehot_%0d", nseq), 32'($onehot(grant)), 32'd1);
        seq[nseq]     = int'(gidx);
        seq_cyc[nseq] = cyc;
        nseq++;
      end
    end
    check("collect_count", 32'(nseq), 32'(cnt));
  endtask

  task automatic run_seq(input string tag, input string exp);
    collect(exp.len());
    for (int k = 0; k < exp.len(); k++) begin
      check($sformatf("%s_%0d", tag, k), 32'(seq[k]), 32'(exp[k] - 8'd48));
    end
  endtask

  initial begin
    string exp_w;
    string exp_bp;
    string exp_flat;
`ifdef LIB_ARB_WRR_EN
    exp_w    = "001233300";
    exp_bp   = "012";
    exp_flat = "0000";
`else
    exp_w    = "012301230";
    exp_bp   = "123";
    exp_flat = "0123";
`endif
    req    = '0;
    last   = '0;
    weight = '0;
    ready  = 1'b0;
    step();
    step();
    check("rst_grant",  32'(grant),  32'd0);
    check("rst_idx",    32'(gidx),   32'd0);
    check("rst_valid",  32'(valid),  32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    reset = 1'b0;

    // Plain round robin, single-beat packets
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    req = '1; last = '1; ready = 1'b1;
    run_seq("rr", "01230");
    check("rr_spacing", 32'(seq_cyc[4] - seq_cyc[0]), 32'd8);
    do_reset();

    // Weights {2,1,1,3} for requesters 0..3
    weight = {4'd3, 4'd1, 4'd1, 4'd2};
    req = '1; last = '1; ready = 1'b1;
    run_seq("wrr", exp_w);
    do_reset();

    // Three-beat packet from requester 1; requester 0 arrives during beat 2
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    req = 4'b0100; last = '0; ready = 1'b1;
    step();
    check("lock_g1", 32'(grant), 32'(4'b0100));
    check("lock_l1", 32'(locked), 32'd0);
    step();
    check("lock_g2", 32'(grant), 32'(4'b0100));
    check("lock_l2", 32'(locked), 32'd1);
    req[0] = 1'b1;
    step();
    check("lock_g3", 32'(grant), 32'(4'b0100));
    check("lock_l3", 32'(locked), 32'd1);
    last[1] = 1'b1;
    step();
    check("lock_end_valid",  32'(valid),  32'd0);
    check("lock_end_locked", 32'(locked), 32'd0);
    req[1] = 1'b0; last = '0;
    step();
    check("lock_next_grant", 32'(grant), 32'(4'b1000));
    check("lock_next_idx",   32'(gidx),  32'd0);
    do_reset();

    // Backpressure: five stalled cycles, then a single accepted beat
    weight = {4'd3, 4'd1, 4'd1, 4'd2};
    req = 4'b1000; last = '1; ready = 1'b0;
    step();
    check("bp_grant", 32'(grant), 32'(4'b1000));
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("bp_hold_%0d", k), 32'(grant), 32'(4'b1000));
    end
    ready = 1'b1;
    step();
    check("bp_done", 32'(valid), 32'd0);
    req = '1;
    run_seq("bp_seq", exp_bp);
    do_reset();

    // Requester 2 drops mid-packet; pointer must move past it
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    req = 4'b0011; last = '0; ready = 1'b1;
    step();
    check("ab_idx", 32'(gidx), 32'd2);
    step();
    check("ab_locked", 32'(locked), 32'd1);
    req = 4'b1001;
    step();
    check("ab_drop_valid",  32'(valid),  32'd0);
    check("ab_drop_locked", 32'(locked), 32'd0);
    step();
    check("ab_next_valid", 32'(valid), 32'd1);
    check("ab_next_idx",   32'(gidx),  32'd3);
    do_reset();

    // Equal weights of 5
    weight = {4'd5, 4'd5, 4'd5, 4'd5};
    req = '1; last = '1; ready = 1'b1;
    run_seq("flat", exp_flat);
    do_reset();

    // Asynchronous reset in the middle of a packet
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    req = 4'b0100; last = '0; ready = 1'b1;
    step();
    step();
    check("mr_pre_grant",  32'(grant),  32'(4'b0100));
    check("mr_pre_locked", 32'(locked), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("mr_grant",  32'(grant),  32'd0);
    check("mr_valid",  32'(valid),  32'd0);
    check("mr_locked", 32'(locked), 32'd0);
    req = '1;
    #2;
    reset = 1'b0;
    step();
    check("mr_first_valid", 32'(valid), 32'd1);
    check("mr_first_idx",   32'(gidx),  32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
